// File: rtl/bus_arbiter.sv
// Round-robin arbiter giving N_REQ cores exclusive access to one shared memory port.
// Define ARB_TIMEOUT_EN to force release after TIMEOUT owned cycles.
//
// state | meaning
// IDLE  | no owner; memory port driven to zero, arbitrating on the next edge
// OWNED | one core granted; its rw/addr/wdata drive the memory port
module bus_arbiter #(
   parameter int N_REQ   = 4,
   parameter int AW      = 9,
   parameter int DW      = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [N_REQ-1:0]          grant_request,
   output logic [N_REQ-1:0]          grant_given,
   input  logic [N_REQ-1:0]          core_rw,
   input  logic [N_REQ*AW-1:0]       core_addr,
   input  logic [N_REQ*DW-1:0]       core_wdata,
   output logic [DW-1:0]             rdata,
   output logic                      mem_rw,
   output logic [AW-1:0]             mem_addr,
   output logic [DW-1:0]             mem_wdata,
   input  logic [DW-1:0]             mem_rdata,
   output logic                      busy,
   output logic [$clog2(N_REQ)-1:0]  owner
);

   localparam int OW = $clog2(N_REQ);

   typedef enum logic {IDLE, OWNED} state_t;

   state_t             state_q;
   logic [N_REQ-1:0]   grant_q;
   logic [OW-1:0]      owner_q;
   logic [OW-1:0]      last_q;
   logic               busy_q;
   logic [OW-1:0]      sel_d;
   logic               found_d;
   logic [N_REQ-1:0]   grant_d;
   logic               release_d;

   // Cores above last_q win first; the second pass wraps around to the rest.
   always_comb begin
      found_d = 1'b0;
      sel_d   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found_d && grant_request[i] && (i > int'(last_q))) begin
            found_d = 1'b1;
            sel_d   = OW'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found_d && grant_request[i]) begin
            found_d = 1'b1;
            sel_d   = OW'(i);
         end
      end
      grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel_d;
   end

`ifdef ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   logic [CW-1:0] cnt_q;
   logic          timeout_hit;

   assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (state_q == OWNED && !timeout_hit) begin
         cnt_q <= cnt_q + CW'(1);
      end else begin
         cnt_q <= '0;
      end
   end
`else
   logic timeout_hit;
   logic unused_timeout;

   assign timeout_hit    = 1'b0;
   assign unused_timeout = (TIMEOUT != 0);
`endif

   assign release_d = !grant_request[owner_q] || timeout_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         grant_q <= '0;
         owner_q <= '0;
         busy_q  <= 1'b0;
         last_q  <= OW'(N_REQ - 1);
      end else begin
         case (state_q)
            IDLE: begin
               if (found_d) begin
                  state_q <= OWNED;
                  grant_q <= grant_d;
                  owner_q <= sel_d;
                  busy_q  <= 1'b1;
                  last_q  <= sel_d;
               end
            end
            OWNED: begin
               if (release_d) begin
                  state_q <= IDLE;
                  grant_q <= '0;
                  owner_q <= '0;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               grant_q <= '0;
               owner_q <= '0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // busy_q clears asynchronously, so a reset kills any write immediately.
   assign mem_rw      = busy_q & core_rw[owner_q];
   assign mem_addr    = busy_q ? core_addr[owner_q*AW +: AW]  : '0;
   assign mem_wdata   = busy_q ? core_wdata[owner_q*DW +: DW] : '0;
   assign rdata       = mem_rdata;
   assign grant_given = grant_q;
   assign owner       = owner_q;
   assign busy        = busy_q;

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesting cores (2..8).
REQ-002 Parameter: AW, 9, shared-memory address width.
REQ-003 Parameter: DW, 8, shared-memory data width.
REQ-004 Parameter: TIMEOUT, 16, max owned cycles before forced release (used only with ARB_TIMEOUT_EN).
REQ-005 Ports, in order:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- grant_request  input  N_REQ  per-core bus request.
- grant_given  output  N_REQ  per-core one-hot grant.
- core_rw  input  N_REQ  per-core rw; 1 = write.
- core_addr  input  N_REQ*AW  packed per-core address; core i at [i*AW +: AW].
- core_wdata  input  N_REQ*DW  packed per-core write data.
- rdata  output  DW  read data broadcast to all cores.
- mem_rw  output  1  shared-memory write enable.
- mem_addr  output  AW  shared-memory address.
- mem_wdata  output  DW  shared-memory write data.
- mem_rdata  input  DW  shared-memory read data.
- busy  output  1  high while any core owns the bus.
- owner  output  clog2(N_REQ)  index of current owner; 0 when idle.

Function
REQ-006 Two-state FSM: IDLE, OWNED; state, grant_given, owner and busy are registered.
REQ-007 IDLE with no request asserted: remain in IDLE, all outputs at idle values.
REQ-008 IDLE with any request asserted: select the first requester in round-robin order starting at (last_owner+1) mod N_REQ; on the next edge assert its grant bit, set owner, set busy, enter OWNED, update last_owner.
REQ-009 Grant latency: request seen at edge k -> grant_given high after edge k+1 (one cycle), when the bus is idle.
REQ-010 grant_given has at most one bit set in every cycle.
REQ-011 OWNED: mem_rw, mem_addr and mem_wdata combinationally mux the owner's core_rw, core_addr and core_wdata; rdata = mem_rdata at all times.
REQ-012 When busy is low: mem_rw = 0, mem_addr = 0, mem_wdata = 0 (no spurious write).
REQ-013 OWNED while owner's request is high: hold the grant; requests from other cores are ignored.
REQ-014 OWNED with owner's request low at an edge: clear the grant and busy, return to IDLE; at least one IDLE cycle occurs between consecutive owners.
REQ-015 When a grant is released, the released core becomes lowest priority for the next arbitration.
REQ-016 Requests raised and dropped in the same IDLE cycle before an edge are not remembered (no request latching).

Reset
REQ-017 reset low asynchronously forces IDLE, grant_given = 0, busy = 0, owner = 0, mem_rw = 0 and last_owner = N_REQ-1, so core 0 wins the first arbitration.
REQ-018 Reset asserted mid-ownership drops the grant and mem_rw in the same cycle, without waiting for a clock edge; no write completes after reset asserts.

Configuration
REQ-019 Macro ARB_TIMEOUT_EN defined: a counter increments each OWNED cycle; when TIMEOUT owned cycles have elapsed, the grant is revoked on the next edge, FSM enters IDLE and the owner becomes lowest priority even if it is still requesting.
REQ-020 ARB_TIMEOUT_EN undefined: no counter logic; ownership lasts until the owner drops its request.

Verification
REQ-021 After reset, grant_request = 4'b1111 -> grant_given = 4'b0001 one cycle later, owner = 0, busy = 1.
REQ-022 Owner 0 drops its request while 4'b1110 stays requested -> one IDLE cycle, then 4'b0010; repeated releases give the order 1, 2, 3, 0.
REQ-023 Core 2 owns the bus with core_rw[2] = 1, addr 9'h1A5, data 8'h3C -> mem_rw = 1, mem_addr = 9'h1A5, mem_wdata = 8'h3C; a release leaves mem_rw = 0 on the following cycle.
REQ-024 Core 1 owns the bus with a write in progress and reset pulses low between edges -> grant_given = 0 and mem_rw = 0 immediately; after release, request 4'b0110 -> grant to core 1.
REQ-025 ARB_TIMEOUT_EN with TIMEOUT = 16: cores 0 and 3 request continuously -> core 0 is held exactly 16 cycles, then 1 IDLE cycle, then core 3 is granted.
REQ-026 No requests for 20 cycles -> grant_given = 0, busy = 0, mem_rw = 0, owner = 0 throughout.
